// File: rtl/wptr_full_level.sv
// Write-side pointer, full/next-full flags, fill level, almost-full and sticky overflow
// for the write clock domain of an asynchronous FIFO.
module wptr_full_level #(
   parameter int unsigned ADDRSIZE = 4
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   input  logic [ADDRSIZE:0]   afull_lvl,
   input  logic                ovf_clr,
   output logic                wen,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic [1:0]          wfull,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                walmost_full,
   output logic                wovf
);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wbin2next;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] wgray_2next;
   logic [ADDRSIZE:0] full_target;
   logic [ADDRSIZE:0] rbin_s;
   logic [ADDRSIZE:0] wlevel_next;
   logic              wfull_val;
   logic              wnextfull_val;

   assign wen         = winc & ~wfull[0];
   assign waddr       = wbin[ADDRSIZE-1:0];
   assign wbinnext    = wbin + {{ADDRSIZE{1'b0}}, wen};
   assign wbin2next   = wbinnext + (ADDRSIZE+1)'(1);
   assign wgraynext   = (wbinnext >> 1) ^ wbinnext;
   assign wgray_2next = (wbin2next >> 1) ^ wbin2next;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_target   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
   assign wfull_val     = (wgraynext == full_target);
   assign wnextfull_val = (wgray_2next == full_target);

   // Each binary bit is the XOR of all Gray bits at and above it.
   always_comb begin
      rbin_s = '0;
      for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
         rbin_s[i] = ^(wq2_rptr >> i);
      end
   end

   assign wlevel_next = wbinnext - rbin_s;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 2'b00;
         wlevel       <= '0;
         walmost_full <= 1'b0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= {wnextfull_val, wfull_val};
         wlevel       <= wlevel_next;
         walmost_full <= (wlevel_next >= afull_lvl);
         if (winc & wfull[0]) begin
            wovf <= 1'b1;
         end else if (ovf_clr) begin
            wovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_level.sv
// Randomized and directed checks of wptr_full_level against an occupancy-count model.
module tb_wptr_full_level;

   localparam int unsigned A = 4;
   localparam int          DEPTH = 16;
   localparam int          MODV  = 32;

   logic         wclk;
   logic         wrst;
   logic         winc;
   logic [A:0]   wq2_rptr;
   logic [A:0]   afull_lvl;
   logic         ovf_clr;
   logic         wen;
   logic [A-1:0] waddr;
   logic [A:0]   wptr;
   logic [1:0]   wfull;
   logic [A:0]   wlevel;
   logic         walmost_full;
   logic         wovf;

   wptr_full_level #(.ADDRSIZE(A)) dut (
      .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
      .afull_lvl(afull_lvl), .ovf_clr(ovf_clr), .wen(wen), .waddr(waddr),
      .wptr(wptr), .wfull(wfull), .wlevel(wlevel),
      .walmost_full(walmost_full), .wovf(wovf)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int total = 0;
   int bad   = 0;

   // model: writes accepted, read position, registered occupancy
   int   m_wb  = 0;
   int   m_rb  = 0;
   int   m_lvl = 0;
   logic m_alm = 1'b0;
   logic m_ovf = 1'b0;
   logic cap_wen;
   logic exp_wen;

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [17:0] exp_vec();
      logic [4:0] wb5;
      wb5 = 5'(m_wb);
      return {gray5(m_wb), wb5[3:0], (m_lvl == DEPTH - 1), (m_lvl == DEPTH),
              5'(m_lvl), m_alm, m_ovf};
   endfunction

   function automatic logic [17:0] act_vec();
      return {wptr, waddr, wfull, wlevel, walmost_full, wovf};
   endfunction

   // Drive one cycle's inputs, capture wen before the edge, advance model at the edge.
   task automatic do_cycle(input logic i_rst, input logic i_inc, input logic i_clr,
                           input int i_rb, input int i_afl);
      logic acc;
      wrst      = i_rst;
      winc      = i_inc;
      ovf_clr   = i_clr;
      wq2_rptr  = gray5(i_rb);
      afull_lvl = 5'(i_afl);
      #1;
      cap_wen = wen;
      exp_wen = i_inc && (m_lvl != DEPTH);
      @(posedge wclk);
      if (i_rst) begin
         m_wb = 0; m_lvl = 0; m_alm = 1'b0; m_ovf = 1'b0;
      end else begin
         acc = i_inc && (m_lvl != DEPTH);
         if (i_inc && m_lvl == DEPTH) m_ovf = 1'b1;
         else if (i_clr)              m_ovf = 1'b0;
         m_wb  = (m_wb + (acc ? 1 : 0)) % MODV;
         m_lvl = (m_wb - i_rb + MODV) % MODV;
         m_alm = (m_lvl >= i_afl);
      end
      m_rb = i_rb;
      @(negedge wclk);
   endtask

   task automatic test_reset();
      do_cycle(1'b1, 1'b1, 1'b0, 0, 12);
      do_cycle(1'b1, 1'b1, 1'b0, 0, 12);
      total++;
      if (act_vec() !== 18'd0) begin
         bad++;
         $display("FAIL reset_state actual=%h required=%h", act_vec(), 18'd0);
      end
      total++;
      if (cap_wen !== 1'b1) begin
         bad++;
         $display("FAIL reset_wen actual=%b required=1", cap_wen);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         do_cycle(1'b0, 1'b1, 1'b0, 0, 12);
         total++;
         if (act_vec() !== exp_vec() || cap_wen !== exp_wen) begin
            bad++;
            $display("FAIL fill_%0d actual=%h wen=%b required=%h wen=%b",
                     i, act_vec(), cap_wen, exp_vec(), exp_wen);
         end
      end
      total++;
      if (wptr !== 5'b11000 || waddr !== 4'd0 || wfull !== 2'b01 || wlevel !== 5'd16) begin
         bad++;
         $display("FAIL fill_full actual=%b/%0d/%b/%0d required=11000/0/01/16",
                  wptr, waddr, wfull, wlevel);
      end
   endtask

   task automatic test_overflow();
      logic [2:0] clr_seq [3];
      logic [2:0] inc_seq [3];
      clr_seq = '{3'd0, 3'd1, 3'd1};
      inc_seq = '{3'd1, 3'd0, 3'd1};
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b0, inc_seq[i][0], clr_seq[i][0], 0, 12);
         total++;
         if (act_vec() !== exp_vec() || cap_wen !== exp_wen) begin
            bad++;
            $display("FAIL overflow_%0d actual=%h wen=%b required=%h wen=%b",
                     i, act_vec(), cap_wen, exp_vec(), exp_wen);
         end
      end
      total++;
      if (wovf !== 1'b1 || wptr !== 5'b11000) begin
         bad++;
         $display("FAIL overflow_sticky actual=%b/%b required=1/11000", wovf, wptr);
      end
   endtask

   task automatic test_drain();
      for (int rb = 4; rb <= 5; rb++) begin
         do_cycle(1'b0, 1'b0, 1'b1, rb, 12);
         total++;
         if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL drain_rb%0d actual=%h required=%h", rb, act_vec(), exp_vec());
         end
      end
      total++;
      if (wlevel !== 5'd11 || walmost_full !== 1'b0 || wfull !== 2'b00) begin
         bad++;
         $display("FAIL drain_final actual=%0d/%b/%b required=11/0/00",
                  wlevel, walmost_full, wfull);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] prev;
      bit saw_wrap = 1'b0;
      for (int i = 0; i < 40; i++) begin
         prev = wptr;
         do_cycle(1'b0, 1'b1, 1'b0, (m_wb - 1 + MODV) % MODV, 12);
         if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
         total++;
         if (act_vec() !== exp_vec() || $countones(prev ^ wptr) != 1 ||
             wlevel !== 5'd2 || wfull !== 2'b00) begin
            bad++;
            $display("FAIL wrap_%0d actual=%h prev_wptr=%b required=%h",
                     i, act_vec(), prev, exp_vec());
         end
      end
      total++;
      if (!saw_wrap) begin
         bad++;
         $display("FAIL wrap_seen actual=0 required=1");
      end
   endtask

   task automatic test_reset_mid();
      do_cycle(1'b1, 1'b0, 1'b0, 0, 12);
      for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b1, 1'b0, 0, 12);
      do_cycle(1'b1, 1'b1, 1'b0, 0, 12);
      total++;
      if (act_vec() !== 18'd0) begin
         bad++;
         $display("FAIL reset_mid actual=%h required=%h", act_vec(), 18'd0);
      end
      do_cycle(1'b0, 1'b1, 1'b0, 0, 12);
      total++;
      if (cap_wen !== 1'b1 || act_vec() !== exp_vec() || waddr !== 4'd1) begin
         bad++;
         $display("FAIL first_write_after_reset actual=%h wen=%b required=%h wen=1",
                  act_vec(), cap_wen, exp_vec());
      end
   endtask

   task automatic test_afull_zero();
      do_cycle(1'b1, 1'b0, 1'b0, 0, 0);
      do_cycle(1'b0, 1'b0, 1'b0, 0, 0);
      total++;
      if (walmost_full !== 1'b1 || wlevel !== 5'd0) begin
         bad++;
         $display("FAIL afull_zero actual=%b/%0d required=1/0", walmost_full, wlevel);
      end
   endtask

   task automatic test_random();
      int rb;
      int afl;
      logic inc;
      logic clr;
      rb  = m_rb;
      afl = $urandom_range(16, 0);
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) afl = $urandom_range(16, 0);
         inc = ($urandom_range(3, 0) != 0);
         clr = ($urandom_range(7, 0) == 0);
         if (((m_wb - rb + MODV) % MODV) > 0 && $urandom_range(2, 0) == 0)
            rb = (rb + 1) % MODV;
         do_cycle(1'b0, inc, clr, rb, afl);
         total++;
         if (act_vec() !== exp_vec() || cap_wen !== exp_wen) begin
            bad++;
            $display("FAIL random_%0d actual=%h wen=%b required=%h wen=%b",
                     i, act_vec(), cap_wen, exp_vec(), exp_wen);
         end
      end
   endtask

   initial begin
      wrst = 1'b1; winc = 1'b0; ovf_clr = 1'b0; wq2_rptr = '0; afull_lvl = 5'd12;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_reset_mid();
      test_afull_zero();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
